// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I opcode constants, immediate-format encodings and the decoded bundle type.
// The bundle carries an illegal flag only when ILLEGAL_DETECT_EN is defined.
package riscv_pkg;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    typedef enum logic [2:0] {IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [6:0] funct7;
        imm_type_e  imm_type;
        logic       wb_en;
`ifdef ILLEGAL_DETECT_EN
        logic       illegal;
`endif
    } dec_t;

    function automatic logic is_rv32i(input logic [6:0] opc);
        return opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
                           OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_SYSTEM, OPC_MISC_MEM};
    endfunction
endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side and execute-side handshake plus the decoded bundle.
// The illegal signal exists only when ILLEGAL_DETECT_EN is defined.
interface decode_stage_if #(parameter int XLEN = 32);
    import riscv_pkg::*;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic            out_valid;
    logic            out_ready;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    imm_type_e       imm_type;
    logic            wb_en;
`ifdef ILLEGAL_DETECT_EN
    logic            illegal;
    modport master (output in_valid, instr, out_ready,
                    input in_ready, out_valid, opcode, rd, funct3, rs1, rs2, funct7, imm, imm_type, wb_en, illegal);
    modport slave (input in_valid, instr, out_ready,
                   output in_ready, out_valid, opcode, rd, funct3, rs1, rs2, funct7, imm, imm_type, wb_en, illegal);
`else
    modport master (output in_valid, instr, out_ready,
                    input in_ready, out_valid, opcode, rd, funct3, rs1, rs2, funct7, imm, imm_type, wb_en);
    modport slave (input in_valid, instr, out_ready,
                   output in_ready, out_valid, opcode, rd, funct3, rs1, rs2, funct7, imm, imm_type, wb_en);
`endif
endinterface

// File: rtl/imm_gen.sv
// imm_gen: classifies the instruction format and builds its immediate, sign-extended to XLEN.
module imm_gen import riscv_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_type_e       imm_type
);
    logic [6:0]  opc;
    logic [31:0] i32;

    always_comb begin
        opc = instr[6:0];
        imm_type = (opc == OPC_LUI || opc == OPC_AUIPC) ? IMM_U :
                   opc == OPC_JAL    ? IMM_J :
                   opc == OPC_BRANCH ? IMM_B :
                   opc == OPC_STORE  ? IMM_S :
                   (opc inside {OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM, OPC_MISC_MEM}) ? IMM_I : IMM_R;
        case (imm_type)
            IMM_I:   i32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   i32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   i32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   i32 = {instr[31:12], 12'b0};
            IMM_J:   i32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: i32 = '0;
        endcase
        imm = XLEN'($signed(i32));
    end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode stage with a SKID_DEPTH-entry output buffer and flush.
// Define ILLEGAL_DETECT_EN to flag illegal encodings and suppress their write-back.
module decode_stage import riscv_pkg::*; #(
    parameter int XLEN       = 32,
    parameter int SKID_DEPTH = 2
) (
    input logic           clk,
    input logic           rst,
    input logic           flush,
    decode_stage_if.slave dif
);
    localparam int CW = $clog2(SKID_DEPTH + 1);

    dec_t            ent_q [SKID_DEPTH];
    logic [XLEN-1:0] imm_q [SKID_DEPTH];
    logic [CW-1:0]   count, count_n, wr_idx;
    logic            acc, ret, wb;
    dec_t            dec;
    logic [XLEN-1:0] imm;
    imm_type_e       imm_type;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (.instr(dif.instr), .imm(imm), .imm_type(imm_type));

    always_comb begin
        dec.opcode   = dif.instr[6:0];
        dec.rd       = dif.instr[11:7];
        dec.funct3   = dif.instr[14:12];
        dec.rs1      = dif.instr[19:15];
        dec.rs2      = dif.instr[24:20];
        dec.funct7   = dif.instr[31:25];
        dec.imm_type = imm_type;
        wb = (dec.opcode inside {OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR}) && dec.rd != 5'd0;
`ifdef ILLEGAL_DETECT_EN
        dec.illegal = !is_rv32i(dec.opcode) || dif.instr[1:0] != 2'b11 ||
                      (dec.opcode == OPC_OP && !(dec.funct7 == 7'h00 || dec.funct7 == 7'h20)) ||
                      (dec.opcode == OPC_OP_IMM && (dec.funct3 == 3'd1 ? dec.funct7 != 7'h00 :
                                                    dec.funct3 == 3'd5 ? !(dec.funct7 == 7'h00 || dec.funct7 == 7'h20) : 1'b0));
        dec.wb_en = wb && !dec.illegal;
`else
        dec.wb_en = wb;
`endif
    end

    // Head of the buffer is always entry 0; a retire shifts the rest down.
    always_comb begin
        acc     = dif.in_valid && dif.in_ready && !flush;
        ret     = dif.out_valid && dif.out_ready;
        wr_idx  = count - CW'(ret);
        count_n = flush ? '0 : count + CW'(acc) - CW'(ret);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count        <= '0;
            dif.in_ready <= 1'b1;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                ent_q[i] <= '0;
                imm_q[i] <= '0;
            end
        end else begin
            count        <= count_n;
            dif.in_ready <= count_n < CW'(SKID_DEPTH);
            if (!flush) begin
                for (int i = 0; i < SKID_DEPTH - 1; i++)
                    if (ret) begin
                        ent_q[i] <= ent_q[i+1];
                        imm_q[i] <= imm_q[i+1];
                    end
                for (int i = 0; i < SKID_DEPTH; i++)
                    if (acc && wr_idx == CW'(i)) begin
                        ent_q[i] <= dec;
                        imm_q[i] <= imm;
                    end
            end
        end
    end

    assign dif.out_valid = count != '0;
    assign dif.opcode    = ent_q[0].opcode;
    assign dif.rd        = ent_q[0].rd;
    assign dif.funct3    = ent_q[0].funct3;
    assign dif.rs1       = ent_q[0].rs1;
    assign dif.rs2       = ent_q[0].rs2;
    assign dif.funct7    = ent_q[0].funct7;
    assign dif.imm       = imm_q[0];
    assign dif.imm_type  = ent_q[0].imm_type;
    assign dif.wb_en     = ent_q[0].wb_en;
`ifdef ILLEGAL_DETECT_EN
    assign dif.illegal   = ent_q[0].illegal;
`endif
endmodule
